// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with sticky overflow/underflow flags and optional watermark (UART_FIFO_WMARK_EN)
module uart_fifo #(
    parameter int Width = 8,
    parameter int Depth = 128,
    localparam int AW = $clog2(Depth),
    localparam int LW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    output logic [Width-1:0] rdata_o,
    output logic             rvalid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o,
    input  logic [LW-1:0]    thresh_i,
    output logic             thresh_o,
    output logic             ovf_o,
    output logic             udf_o
);

    logic [Width-1:0] mem [Depth];
    logic [LW-1:0]    wptr;
    logic [LW-1:0]    rptr;
    logic             ra;
    logic             wa;

    // Extra MSB on each pointer distinguishes full from empty when addresses match.
    assign empty_o = (wptr == rptr);
    assign full_o  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign level_o = wptr - rptr;

    assign ra = re_i & ~empty_o & ~clr_i;
    assign wa = we_i & (~full_o | ra) & ~clr_i;

    always_ff @(posedge clk_i) begin
        if (wa) begin
            mem[wptr[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr     <= '0;
            rptr     <= '0;
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
            ovf_o    <= 1'b0;
            udf_o    <= 1'b0;
        end else if (clr_i) begin
            wptr     <= '0;
            rptr     <= '0;
            rvalid_o <= 1'b0;
            ovf_o    <= 1'b0;
            udf_o    <= 1'b0;
        end else begin
            if (wa) begin
                wptr <= wptr + LW'(1);
            end
            if (ra) begin
                rptr    <= rptr + LW'(1);
                rdata_o <= mem[rptr[AW-1:0]];
            end
            rvalid_o <= ra;
            if (we_i && !wa) begin
                ovf_o <= 1'b1;
            end
            if (re_i && !ra) begin
                udf_o <= 1'b1;
            end
        end
    end

`ifdef UART_FIFO_WMARK_EN
    assign thresh_o = (level_o >= thresh_i) && (thresh_i != '0);
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh_i;
    assign thresh_o      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - randomized and directed checks of uart_fifo against a queue model
module tb_uart_fifo;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int LW = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clr_i = 1'b0;
    logic          we_i = 1'b0;
    logic          re_i = 1'b0;
    logic [W-1:0]  wdata_i = '0;
    logic [LW-1:0] thresh_i = '0;
    logic [W-1:0]  rdata_o;
    logic          rvalid_o;
    logic          full_o;
    logic          empty_o;
    logic [LW-1:0] level_o;
    logic          thresh_o;
    logic          ovf_o;
    logic          udf_o;

    uart_fifo #(.Width(W), .Depth(D)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
        .we_i(we_i), .wdata_i(wdata_i), .re_i(re_i),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o),
        .full_o(full_o), .empty_o(empty_o), .level_o(level_o),
        .thresh_i(thresh_i), .thresh_o(thresh_o),
        .ovf_o(ovf_o), .udf_o(udf_o)
    );

    always #5 clk_i = ~clk_i;

    int ncmp = 0;
    int nfail = 0;

    logic [W-1:0] q[$];
    logic         m_ovf = 1'b0;
    logic         m_udf = 1'b0;
    logic         m_rvalid = 1'b0;
    logic [W-1:0] m_rdata = '0;

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_thresh();
`ifdef UART_FIFO_WMARK_EN
        return int'((q.size() >= int'(thresh_i)) && (thresh_i != '0));
`else
        return 0;
`endif
    endfunction

    task automatic check_all();
        chk("level", int'(level_o), q.size());
        chk("full", int'(full_o), int'(q.size() == D));
        chk("empty", int'(empty_o), int'(q.size() == 0));
        chk("rvalid", int'(rvalid_o), int'(m_rvalid));
        chk("rdata", int'(rdata_o), int'(m_rdata));
        chk("ovf", int'(ovf_o), int'(m_ovf));
        chk("udf", int'(udf_o), int'(m_udf));
        chk("thresh", int'(thresh_o), m_thresh());
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    // Next state from the current inputs: read pops the oldest word before the write lands.
    task automatic model_step();
        bit rd_ok;
        bit wr_ok;
        if (clr_i) begin
            q.delete();
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
            m_rvalid = 1'b0;
        end else begin
            rd_ok = re_i && (q.size() > 0);
            wr_ok = we_i && ((q.size() < D) || rd_ok);
            if (rd_ok) m_rdata = q.pop_front();
            m_rvalid = rd_ok;
            if (wr_ok) q.push_back(wdata_i);
            if (we_i && !wr_ok) m_ovf = 1'b1;
            if (re_i && !rd_ok) m_udf = 1'b1;
        end
    endtask

    task automatic cyc(input logic we, input logic [W-1:0] wd, input logic re, input logic clr);
        we_i    = we;
        wdata_i = wd;
        re_i    = re;
        clr_i   = clr;
        @(negedge clk_i);
        check_all();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int pw;
        #1;
        model_reset();
        check_all();
        chk("rst_empty_lit", int'(empty_o), 1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Fill, overflow, drain in order
        for (int i = 0; i < 4; i++) cyc(1'b1, W'(8'hA0 + i), 1'b0, 1'b0);
        chk("fill_full_lit", int'(full_o), 1);
        chk("fill_level_lit", int'(level_o), 4);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_lit", int'(ovf_o), 1);
        chk("ovf_level_lit", int'(level_o), 4);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk("drain_data_lit", int'(rdata_o), 8'hA0 + i);
            chk("drain_rvalid_lit", int'(rvalid_o), 1);
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("drain_rvalid_low_lit", int'(rvalid_o), 0);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Underflow then flush
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("udf_rvalid_lit", int'(rvalid_o), 0);
        chk("udf_lit", int'(udf_o), 1);
        chk("udf_level_lit", int'(level_o), 0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("udf_clr_lit", int'(udf_o), 0);

        // Empty with simultaneous write and read
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        chk("empty_wr_level_lit", int'(level_o), 1);
        chk("empty_wr_udf_lit", int'(udf_o), 1);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Full with simultaneous write and read
        for (int i = 0; i < 4; i++) cyc(1'b1, W'(8'hB0 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hC0, 1'b1, 1'b0);
        chk("full_rw_data_lit", int'(rdata_o), 8'hB0);
        chk("full_rw_level_lit", int'(level_o), 4);
        chk("full_rw_ovf_lit", int'(ovf_o), 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("full_rw_last_lit", int'(rdata_o), 8'hC0);

        // Wrap through the pointers
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, W'(i), 1'b0, 1'b0);
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk("wrap_data_lit", int'(rdata_o), i);
        end
        chk("wrap_empty_lit", int'(empty_o), 1);

`ifdef UART_FIFO_WMARK_EN
        thresh_i = 3'd3;
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0);
        #1;
        chk("wmark_l2_lit", int'(thresh_o), 0);
        cyc(1'b1, 8'h03, 1'b0, 1'b0);
        #1;
        chk("wmark_l3_lit", int'(thresh_o), 1);
        thresh_i = 3'd0;
        #1;
        chk("wmark_zero_lit", int'(thresh_o), 0);
        cyc(1'b0, '0, 1'b0, 1'b1);
`endif

        // Asynchronous reset with content held
        for (int i = 0; i < 3; i++) cyc(1'b1, W'(8'hD0 + i), 1'b0, 1'b0);
        we_i = 1'b0;
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        chk("arst_empty_lit", int'(empty_o), 1);
        chk("arst_level_lit", int'(level_o), 0);
        chk("arst_ovf_lit", int'(ovf_o), 0);
        check_all();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("arst_udf_lit", int'(udf_o), 1);
        chk("arst_rvalid_lit", int'(rvalid_o), 0);

        // Randomized traffic, alternating fill- and drain-biased phases
        for (int n = 0; n < 3000; n++) begin
            pw = ((n / 200) % 2 == 0) ? 70 : 30;
            thresh_i = LW'($urandom_range(0, 7));
            cyc($urandom_range(0, 99) < pw, W'($urandom), $urandom_range(0, 99) < (100 - pw),
                $urandom_range(0, 63) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 Parameter: Width, 8, data bits per entry (1..32).
REQ-002 Parameter: Depth, 128, entry count; power of two, 4..1024.
REQ-003 Derived: AW = $clog2(Depth); level width LW = AW+1.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 clr_i  in  1  synchronous flush.
REQ-007 we_i  in  1  write request.
REQ-008 wdata_i  in  Width  write data.
REQ-009 re_i  in  1  read request.
REQ-010 rdata_o  out  Width  read data, registered.
REQ-011 rvalid_o  out  1  rdata_o valid pulse.
REQ-012 full_o  out  1  level == Depth.
REQ-013 empty_o  out  1  level == 0.
REQ-014 level_o  out  LW  current occupancy.
REQ-015 thresh_i  in  LW  watermark level.
REQ-016 thresh_o  out  1  watermark reached.
REQ-017 ovf_o  out  1  sticky overflow.
REQ-018 udf_o  out  1  sticky underflow.

Function
REQ-019 Read accept: ra = re_i & ~empty_o & ~clr_i.
REQ-020 Write accept: wa = we_i & (~full_o | ra) & ~clr_i; write into a full FIFO allowed only with a same-cycle accepted read.
REQ-021 Pointers: AW+1-bit wptr/rptr; increment on wa/ra; wrap Depth-1 -> 0 in the address bits, MSB toggles.
REQ-022 full_o/empty_o combinational from pointers: empty on full-pointer equality; full on equal address bits and differing MSB.
REQ-023 level_o = wptr - rptr, modulo 2^(AW+1); range 0..Depth.
REQ-024 On wa, wdata_i stored at wptr[AW-1:0] in the same edge.
REQ-025 On ra, entry at rptr[AW-1:0] loaded into rdata_o at that edge; rvalid_o high for exactly the following cycle; rdata_o holds its value otherwise.
REQ-026 Latency: a word written at edge N is readable via ra at edge N+1 at the earliest; no write-to-read bypass.
REQ-027 Simultaneous wa and ra: level unchanged; read returns oldest entry, never the word being written.
REQ-028 Empty and we_i & re_i: write accepted, read rejected, udf_o set.
REQ-029 ovf_o set when we_i & ~clr_i & ~wa; udf_o set when re_i & ~clr_i & ~ra; both held until clr_i or reset.
REQ-030 clr_i: pointers, ovf_o, udf_o, rvalid_o -> 0 next edge; overrides we_i/re_i; storage contents untouched; rdata_o holds.

Reset
REQ-031 rst_ni low: pointers 0, rdata_o 0, rvalid_o 0, ovf_o 0, udf_o 0; full_o 0, empty_o 1, level_o 0, thresh_o 0 during and after reset.
REQ-032 Reset mid-transfer discards all content; no partial word is readable after reset release.
REQ-033 Storage array is not reset.

Configuration
REQ-034 Macro UART_FIFO_WMARK_EN defined: thresh_o = (level_o >= thresh_i) & (thresh_i != 0), combinational.
REQ-035 Macro UART_FIFO_WMARK_EN undefined: thresh_i ignored, thresh_o tied 0, no comparator logic.

Verification
REQ-036 Depth=4: write A,B,C,D -> full_o=1, level_o=4; fifth we_i -> ovf_o=1, level_o stays 4; read four -> A,B,C,D in order, each with one rvalid_o cycle.
REQ-037 Empty, re_i for one cycle -> rvalid_o=0, udf_o=1, level_o=0; then clr_i -> udf_o=0.
REQ-038 Full (Depth=4), we_i & re_i same cycle -> oldest word returned, new word accepted, level_o=4, ovf_o=0.
REQ-039 Wrap: 10 write/read pairs through Depth=4 with data 0..9 -> read sequence 0..9, empty_o=1 at end.
REQ-040 UART_FIFO_WMARK_EN, thresh_i=3: level_o 2 -> thresh_o=0, level_o 3 -> thresh_o=1; thresh_i=0 -> thresh_o=0.
REQ-041 rst_ni asserted with level_o=3 -> empty_o=1, level_o=0, ovf_o=0 immediately; first read after release flags underflow.
